// File: rtl/bitonic_sort_iter_pkg.sv
// Shared types and helper functions for the iterative bitonic sorter.
package bitonic_pkg;

    // Controller states: waiting for a vector, running passes, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the pass counters s and j; comfortably covers any practical log2(N).
    localparam int CNT_W = 8;

    // Ceiling log2 for elaboration-time sizing (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Total bitonic passes for L = log2(N) stages.
    function automatic int num_passes(input int l);
        return (l * (l + 32'sd1)) / 32'sd2;
    endfunction

    // Key comparison a > b; operands arrive already extended to 64 bits.
    function automatic logic key_gt(input logic [63:0] a, input logic [63:0] b,
                                    input logic signed_mode);
        logic gt;
        if (signed_mode) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
        return gt;
    endfunction

endpackage

// File: rtl/bitonic_sort_iter_if.sv
// Handshake bundle between a vector source/sink and the bitonic sorter.
interface bitonic_sort_iter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic                 in_descend;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic                 busy;

    modport master (
        output in_valid, in_data, in_descend, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_descend, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/bitonic_sort_iter_cmp_layer.sv
// One combinational compare-exchange layer for bitonic pass (s, j).
// Element pairs are enumerated directly (k -> insert a 0 at bit j) so
// every element is written exactly once per pass.
module bitonic_cmp_layer
    import bitonic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N      = 8,
    parameter int SIGNED = 0
) (
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0]   s,
    input  logic [CNT_W-1:0]   j,
    input  logic               descend,
    output logic [N*WIDTH-1:0] data_out
);
    localparam int IDX_W = clog2(N);

    logic [WIDTH-1:0] elem_s [N];
    logic [WIDTH-1:0] res_s  [N];

    // Widen a key so signed keys order correctly inside the shared compare.
    function automatic logic [63:0] ext_key(input logic [WIDTH-1:0] x);
        logic [63:0] r;
        if (SIGNED != 0) begin
            r = 64'($signed(x));
        end else begin
            r = 64'(x);
        end
        return r;
    endfunction

    // Unpack the flat input vector into elements.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elem_s[i] = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Compare-exchange every pair (lo, lo + 2^j); swap only when strictly out of order.
    always_comb begin : exch
        logic [31:0]      lo32;
        logic [31:0]      hi32;
        logic [IDX_W-1:0] lo_idx;
        logic [IDX_W-1:0] hi_idx;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             asc;
        logic             swap;
        lo32   = 32'd0;
        hi32   = 32'd0;
        lo_idx = {IDX_W{1'b0}};
        hi_idx = {IDX_W{1'b0}};
        a      = {WIDTH{1'b0}};
        b      = {WIDTH{1'b0}};
        asc    = 1'b1;
        swap   = 1'b0;
        for (int i = 0; i < N; i++) begin
            res_s[i] = elem_s[i];
        end
        for (int k = 0; k < N/2; k++) begin
            lo32   = ((32'(k) >> j) << (j + 8'd1)) | (32'(k) & ((32'd1 << j) - 32'd1));
            hi32   = lo32 | (32'd1 << j);
            lo_idx = IDX_W'(lo32);
            hi_idx = IDX_W'(hi32);
            a      = elem_s[lo_idx];
            b      = elem_s[hi_idx];
            // Bit s of the index picks the half-direction; for s == L it is always 0.
            asc    = ((((lo32 >> s) & 32'd1) != 32'd0) == descend);
            swap   = asc ? key_gt(ext_key(a), ext_key(b), SIGNED != 0)
                         : key_gt(ext_key(b), ext_key(a), SIGNED != 0);
            res_s[lo_idx] = swap ? b : a;
            res_s[hi_idx] = swap ? a : b;
        end
    end

    // Repack the exchanged elements.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_out[i*WIDTH +: WIDTH] = res_s[i];
        end
    end
endmodule

// File: rtl/bitonic_sort_iter.sv
// Iterative bitonic sorter: one shared compare-exchange layer applied once
// per clock over all log2(N)*(log2(N)+1)/2 passes of a captured vector.
module bitonic_sort_iter
    import bitonic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N      = 8,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    bitonic_sort_iter_if.slave  bus
);
    localparam int               L   = clog2(N);
    localparam logic [CNT_W-1:0] L_C = CNT_W'(L);

    state_t               state_r;
    logic [CNT_W-1:0]     s_r;
    logic [CNT_W-1:0]     j_r;
    logic                 descend_r;
    logic [N*WIDTH-1:0]   data_r;
    logic [N*WIDTH-1:0]   layer_out_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;

    bitonic_cmp_layer #(
        .WIDTH  (WIDTH),
        .N      (N),
        .SIGNED (SIGNED)
    ) u_layer (
        .data_in  (data_r),
        .s        (s_r),
        .j        (j_r),
        .descend  (descend_r),
        .data_out (layer_out_s)
    );

    // in_ready is held low during reset so nothing is accepted while rst is high.
    assign bus.in_ready  = in_ready_r & ~rst;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_r;
    assign bus.busy      = busy_r;

    // Controller: accept, run one pass per edge, then hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            s_r         <= {CNT_W{1'b0}};
            j_r         <= {CNT_W{1'b0}};
            descend_r   <= 1'b0;
            data_r      <= {(N*WIDTH){1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_r     <= bus.in_data;
                        descend_r  <= bus.in_descend;
                        s_r        <= 8'd1;
                        j_r        <= 8'd0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= SORT;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                SORT: begin
                    data_r <= layer_out_s;
                    if (j_r == 8'd0) begin
                        if (s_r == L_C) begin
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            // Next stage starts at j = (s+1)-1 = s.
                            s_r <= s_r + 8'd1;
                            j_r <= s_r;
                        end
                    end else begin
                        j_r <= j_r - 8'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/bitonic_sort_iter.md
Name: bitonic_sort_iter

Overview:
- Iterative, parametrised bitonic sorter for a full N-element vector of WIDTH-bit keys.
- One vector is accepted over a valid/ready handshake.
- A single registered compare-exchange layer is reused once per cycle over all log2(N)*(log2(N)+1)/2 bitonic passes.
- The sorted vector is presented over a second valid/ready handshake.
- Generalises the fixed-stage merge blocks: any power-of-two N, runtime ascending/descending mode, signed keys, flow control. It trades area for latency compared with the fully unrolled stage chain.

Parameters:
- WIDTH, 8, key width in bits (>=1).
- N, 8, element count; power of two, >=2.
- SIGNED, 0, 1 = keys compared as two's complement, 0 = unsigned.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high; clock clk.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  N*WIDTH  element i at bits [i*WIDTH +: WIDTH].
- in_descend  input  1  0 = ascending, 1 = descending; sampled with in_data.
- out_valid  output  1  sorted vector valid.
- out_ready  input  1  downstream accepts the sorted vector.
- out_data  output  N*WIDTH  sorted vector, same packing; element 0 is the first in sort order.
- busy  output  1  high in SORT or DONE.

Behaviour:
- Constants: L = log2(N); P = L*(L+1)/2 passes (N=8 -> 6; N=16 -> 10).
- State machine:
  - IDLE: in_ready=1. On in_valid, load the data register and latch mode; pass counters s=1, j=0; go to SORT.
  - SORT: one pass per clock edge. After the pass with s=L, j=0, go to DONE.
  - DONE: out_valid=1, out_data = data register, held stable. On out_ready, go to IDLE.
- Pass (s, j) compares elements i and i+2^j, for every i with bit j of i equal to 0.
  - Direction is ascending when ((i>>s)&1) XOR descend == 0; for s==L the (i>>s) bit is 0.
  - The pair swaps only when strictly out of order. Equal keys are never swapped; the sort is not stable.
- Counter sequencing: j decrements from s-1 to 0, then s increments and j restarts at s-1. The first pass is s=1, j=0.
- Latency: accept at edge E. The P passes occur at edges E+1..E+P. out_valid is high from edge E+P until out_ready handshake.
- Throughput: in_ready is low throughout SORT and DONE. The next accept is possible at the earliest one edge after the out handshake edge, i.e. one vector per >= P+2 cycles.
- Comparison: SIGNED=1 uses signed compare of the full WIDTH; SIGNED=0 uses unsigned.
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, busy=0, counters 0.
  - in_ready=0 while rst is high; 1 from the first cycle after rst falls.
- Reset mid-operation (SORT or DONE): the vector is discarded and no out_valid is produced.
- in_valid while not in IDLE: ignored, and the vector is not consumed. The upstream source holds it per the handshake.
- in_descend is used only at accept; later changes have no effect on the vector in flight.
- out_ready while not in DONE: ignored.
- N=2: P=1, a single compare.

Decomposition:
- Shared package bitonic_pkg:
  - state enum {IDLE, SORT, DONE}.
  - function clog2.
  - function num_passes(L).
  - a compare function (a, b, signed_mode) returning a>b.
- Sub-module bitonic_cmp_layer: combinational single compare-exchange layer.
  - Parameters WIDTH, N, SIGNED.
  - Inputs: data vector, s, j, descend.
  - Output: exchanged vector.
- The top level holds the FSM, counters and data register.

Test Plan:
- N=8, W=8, SIGNED=0: in_data elements [5,3,7,1,0,6,2,4], in_descend=0, out_ready=1 -> out_data [0,1,2,3,4,5,6,7]; out_valid exactly 6 edges after accept, high 1 cycle.
- Same input with in_descend=1 -> out_data [7,6,5,4,3,2,1,0].
- Duplicates: [2,0,2,1,1,2,0,1] ascending -> [0,0,1,1,1,2,2,2]; all-equal [9 x8] -> unchanged.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, out_valid high, in_ready=0, a new in_valid is not accepted. out_ready=1 -> in_ready=1 on the next cycle.
- SIGNED=1: [0x80,0x7F,0xFF,0x00,0x01,0xFE,0x10,0xF0] ascending -> [0x80,0xF0,0xFE,0xFF,0x00,0x01,0x10,0x7F].
- rst asserted at the 3rd SORT cycle -> out_valid never rises, busy=0 and out_data=0 after the reset edge, in_ready=1 once rst falls. The next vector then sorts correctly.
